// File: rtl/trivium_pkg.sv
// Shared definitions for the Trivium sequencing controller.
//   ctrl_state_t      : controller state encoding
//   SIG_*             : bit positions in the core's one-hot status word
//   DEF_KEY_W/BLK_LEN : default key width and bytes per data strobe
package trivium_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT_KEY,
    ST_WAIT_INIT,
    ST_READY,
    ST_STROBE,
    ST_STREAM,
    ST_DRAIN,
    ST_ERR
  } ctrl_state_t;

  localparam int unsigned SIG_WAIT_DATA    = 2;
  localparam int unsigned SIG_SECRET_READY = 4;
  localparam int unsigned SIG_ERROR        = 5;

  localparam int unsigned DEF_KEY_W   = 80;
  localparam int unsigned DEF_BLK_LEN = 256;

endpackage

// File: rtl/trivium_out_fifo.sv
// Single-clock output FIFO for the keystream bytes.
//   push/wdata : write side; ignored when full
//   pop/rdata  : read side; rdata is the current head, pop ignored when empty
//   full/empty : occupancy flags
//   count      : number of stored entries (0..DEPTH)
module trivium_out_fifo #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Explicit wrap keeps non-power-of-two depths correct.
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: contents are only visible through count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/trivium_ctrl.sv
// Sequencing controller for the Trivium keystream core.
//   clk, rst (async, active low)
//   key_in/key_valid/key_ready     : 80-bit key handshake (accepted in IDLE only)
//   din/din_valid/din_ready        : plaintext byte that starts one block
//   dout/dout_valid/dout_ready     : buffered keystream bytes to the host
//   busy, err                      : status; err is sticky until reset
//   core_key/core_strob_key        : serial key, MSB first, 80-cycle strobe
//   core_data/core_strob_data      : block byte and one-cycle block strobe
//   core_fifo_cnd                  : FIFO fill state reported to the core
//   core_stream/core_wt_sgn        : core output byte and write strobe
//   core_sign_reg                  : core one-hot status
module trivium_ctrl
  import trivium_pkg::*;
#(
  parameter int unsigned KEY_W        = DEF_KEY_W,
  parameter int unsigned BLK_LEN      = DEF_BLK_LEN,
  parameter int unsigned FIFO_DEPTH   = 256,
  parameter int unsigned INIT_TIMEOUT = 2048
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key_in,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic [7:0]       din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [7:0]       dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             err,
  output logic             core_key,
  output logic             core_strob_key,
  output logic [7:0]       core_data,
  output logic             core_strob_data,
  output logic [1:0]       core_fifo_cnd,
  input  logic [7:0]       core_stream,
  input  logic             core_wt_sgn,
  input  logic [7:0]       core_sign_reg
);

  localparam int unsigned KCW = (KEY_W > 1) ? $clog2(KEY_W) : 1;
  localparam int unsigned TW  = $clog2(INIT_TIMEOUT) + 1;
  localparam int unsigned BCW = $clog2(BLK_LEN) + 1;
  localparam int unsigned FCW = $clog2(FIFO_DEPTH) + 1;

  ctrl_state_t      state_q, state_d;
  logic [KEY_W-1:0] key_sr_q, key_sr_d;
  logic [KCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [BCW-1:0]   blk_cnt_q, blk_cnt_d;
  logic [7:0]       core_data_q, core_data_d;
  logic             strob_q, strob_d;
  logic [1:0]       fifo_cnd_q, fifo_cnd_d;

  logic             fifo_push, fifo_pop;
  logic             fifo_full, fifo_empty;
  logic [7:0]       fifo_rdata;
  logic [FCW-1:0]   fifo_count;
  logic             wt_err;
  logic             head_valid;
  logic             sign_unused;

  // Only the Wait_Data bit steers the controller.
  assign sign_unused = ^core_sign_reg;

  assign fifo_push  = core_wt_sgn && (state_q == ST_STREAM) && !fifo_full;
  assign wt_err     = core_wt_sgn && ((state_q != ST_STREAM) || fifo_full);
  assign head_valid = !fifo_empty && (state_q != ST_ERR);
  assign fifo_pop   = head_valid && dout_ready;

  trivium_out_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (fifo_push),
    .wdata (core_stream),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d     = state_q;
    key_sr_d    = key_sr_q;
    bit_cnt_d   = bit_cnt_q;
    timer_d     = timer_q;
    blk_cnt_d   = blk_cnt_q;
    core_data_d = core_data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (key_valid) begin
          key_sr_d  = key_in;
          bit_cnt_d = '0;
          state_d   = ST_SHIFT_KEY;
        end
      end
      ST_SHIFT_KEY: begin
        key_sr_d  = {key_sr_q[KEY_W-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == KCW'(KEY_W - 1)) begin
          timer_d = '0;
          state_d = ST_WAIT_INIT;
        end
      end
      ST_WAIT_INIT: begin
        timer_d = timer_q + 1'b1;
        // Core readiness wins over a timeout landing in the same cycle.
        if (core_sign_reg[SIG_WAIT_DATA]) begin
          state_d = ST_READY;
        end else if (timer_q == TW'(INIT_TIMEOUT - 1)) begin
          state_d = ST_ERR;
        end
      end
      ST_READY: begin
        if (din_valid && fifo_empty) begin
          core_data_d = din;
          state_d     = ST_STROBE;
        end
      end
      ST_STROBE: begin
        blk_cnt_d = '0;
        state_d   = ST_STREAM;
      end
      ST_STREAM: begin
        if (fifo_push) begin
          blk_cnt_d = blk_cnt_q + 1'b1;
          if (blk_cnt_d == BCW'(BLK_LEN)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (fifo_empty && core_sign_reg[SIG_WAIT_DATA]) begin
          state_d = ST_READY;
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_ERR;
      end
    endcase

    if (wt_err) begin
      state_d = ST_ERR;
    end

    // The strobe is registered off the STROBE state so core_data is
    // already stable for a full cycle when the core sees it.
    strob_d = (state_q == ST_STROBE) && (state_d == ST_STREAM);

    // Three-level fill state: 00 empty, 01 partially filled, 10 full.
    fifo_cnd_d = {fifo_count == FCW'(FIFO_DEPTH),
                  (fifo_count != '0) && (fifo_count != FCW'(FIFO_DEPTH))};

    // Output decode.
    key_ready       = rst && (state_q == ST_IDLE);
    din_ready       = (state_q == ST_READY) && fifo_empty;
    dout_valid      = head_valid;
    dout            = head_valid ? fifo_rdata : '0;
    busy            = (state_q != ST_IDLE) && (state_q != ST_READY);
    err             = (state_q == ST_ERR);
    core_strob_key  = (state_q == ST_SHIFT_KEY);
    core_key        = (state_q == ST_SHIFT_KEY) ? key_sr_q[KEY_W-1] : 1'b0;
    core_data       = core_data_q;
    core_strob_data = strob_q;
    core_fifo_cnd   = fifo_cnd_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      key_sr_q    <= '0;
      bit_cnt_q   <= '0;
      timer_q     <= '0;
      blk_cnt_q   <= '0;
      core_data_q <= '0;
      strob_q     <= 1'b0;
      fifo_cnd_q  <= '0;
    end else begin
      state_q     <= state_d;
      key_sr_q    <= key_sr_d;
      bit_cnt_q   <= bit_cnt_d;
      timer_q     <= timer_d;
      blk_cnt_q   <= blk_cnt_d;
      core_data_q <= core_data_d;
      strob_q     <= strob_d;
      fifo_cnd_q  <= fifo_cnd_d;
    end
  end

endmodule

// File: tb/tb_trivium_ctrl.sv
// Self-checking bench for trivium_ctrl: key serialisation, init handshake,
// block streaming through the output FIFO, backpressure overflow, init
// timeout and asynchronous reset in mid-stream.
module tb_trivium_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [79:0] key_in = '0;
  logic        key_valid = 1'b0;
  logic        key_ready;
  logic [7:0]  din = '0;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        dout_ready = 1'b0;
  logic        busy;
  logic        err;
  logic        core_key;
  logic        core_strob_key;
  logic [7:0]  core_data;
  logic        core_strob_data;
  logic [1:0]  core_fifo_cnd;
  logic [7:0]  core_stream = '0;
  logic        core_wt_sgn = 1'b0;
  logic [7:0]  core_sign_reg = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  trivium_ctrl #(
    .KEY_W        (80),
    .BLK_LEN      (256),
    .FIFO_DEPTH   (256),
    .INIT_TIMEOUT (2048)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .key_in          (key_in),
    .key_valid       (key_valid),
    .key_ready       (key_ready),
    .din             (din),
    .din_valid       (din_valid),
    .din_ready       (din_ready),
    .dout            (dout),
    .dout_valid      (dout_valid),
    .dout_ready      (dout_ready),
    .busy            (busy),
    .err             (err),
    .core_key        (core_key),
    .core_strob_key  (core_strob_key),
    .core_data       (core_data),
    .core_strob_data (core_strob_data),
    .core_fifo_cnd   (core_fifo_cnd),
    .core_stream     (core_stream),
    .core_wt_sgn     (core_wt_sgn),
    .core_sign_reg   (core_sign_reg)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    key_valid = 1'b0; din_valid = 1'b0; dout_ready = 1'b0;
    core_wt_sgn = 1'b0; core_sign_reg = '0;
    step(); step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    logic [13:0] outs;
    #1;
    outs = {key_ready, din_ready, dout_valid, busy, err, core_key, core_strob_key,
            core_strob_data, core_fifo_cnd, |dout, |core_data, 2'b00};
    checks++;
    if (outs !== '0) begin
      errors++; $display("FAIL reset_outputs: got %0h want 0", outs);
    end
    step();
    checks++;
    if ({key_ready, busy, err, dout_valid, core_fifo_cnd} !== 6'b0) begin
      errors++; $display("FAIL reset_held: got %0h want 0",
                         {key_ready, busy, err, dout_valid, core_fifo_cnd});
    end
    rst = 1'b1;
    step();
    checks++;
    if ({key_ready, busy, err} !== 3'b100) begin
      errors++; $display("FAIL idle_after_reset: got %0b want 100", {key_ready, busy, err});
    end
  endtask

  task automatic test_key_load(input logic [79:0] k);
    checks++;
    if (key_ready !== 1'b1) begin
      errors++; $display("FAIL key_ready_idle: got %0b want 1", key_ready);
    end
    key_in = k; key_valid = 1'b1;
    step();
    key_valid = 1'b0; key_in = 80'({$urandom(), $urandom(), $urandom()});
    for (int i = 0; i < 80; i++) begin
      checks++;
      if ({core_strob_key, core_key, busy} !== {1'b1, k[79-i], 1'b1}) begin
        errors++; $display("FAIL key_bit%0d: got %0b want %0b", i,
                           {core_strob_key, core_key, busy}, {1'b1, k[79-i], 1'b1});
      end
      step();
    end
    checks++;
    if ({core_strob_key, busy} !== 2'b01) begin
      errors++; $display("FAIL key_strobe_end: got %0b want 01", {core_strob_key, busy});
    end
  endtask

  task automatic test_init_complete(input int delay);
    core_sign_reg = 8'h00;
    repeat (delay) step();
    checks++;
    if ({busy, din_ready, err} !== 3'b100) begin
      errors++; $display("FAIL wait_init: got %0b want 100", {busy, din_ready, err});
    end
    core_sign_reg = 8'h04;
    step();
    checks++;
    if ({din_ready, busy, err} !== 3'b100) begin
      errors++; $display("FAIL init_ready: got %0b want 100", {din_ready, busy, err});
    end
  endtask

  // Handshake a byte in READY and check the data/strobe ordering.
  task automatic start_block(input logic [7:0] b);
    checks++;
    if (din_ready !== 1'b1) begin
      errors++; $display("FAIL din_ready_ready: got %0b want 1", din_ready);
    end
    din = b; din_valid = 1'b1;
    step();
    din_valid = 1'b0; din = 8'($urandom());
    checks++;
    if ({core_strob_data, busy, din_ready} !== 3'b010 || core_data !== b) begin
      errors++; $display("FAIL pre_strobe: got %0b/%0h want 010/%0h",
                         {core_strob_data, busy, din_ready}, core_data, b);
    end
    step();
    checks++;
    if (core_strob_data !== 1'b1 || core_data !== b) begin
      errors++; $display("FAIL strobe: got %0b/%0h want 1/%0h", core_strob_data, core_data, b);
    end
    core_sign_reg = 8'h10;
    step();
    checks++;
    if (core_strob_data !== 1'b0) begin
      errors++; $display("FAIL strobe_width: got %0b want 0", core_strob_data);
    end
  endtask

  task automatic test_block(input bit directed);
    logic [7:0] q[$];
    logic [7:0] b, data;
    logic [1:0] cnd_exp;
    int sent, cyc;
    bit wt, dr, done;
    b = directed ? 8'hA5 : 8'($urandom());
    start_block(b);
    sent = 0; cyc = 0; done = 1'b0; cnd_exp = 2'b00;
    while (!done && cyc < 5000) begin
      checks++;
      if (dout_valid !== (q.size() > 0)) begin
        errors++; $display("FAIL dout_valid c%0d: got %0b want %0b", cyc, dout_valid, q.size() > 0);
      end
      if (q.size() > 0) begin
        checks++;
        if (dout !== q[0]) begin
          errors++; $display("FAIL dout c%0d: got %0h want %0h", cyc, dout, q[0]);
        end
      end
      checks++;
      if (core_fifo_cnd !== cnd_exp || core_data !== b) begin
        errors++; $display("FAIL cnd_hold c%0d: got %0b/%0h want %0b/%0h",
                           cyc, core_fifo_cnd, core_data, cnd_exp, b);
      end
      if (sent == 256 && q.size() == 0) begin
        done = 1'b1;
      end else begin
        cnd_exp = (q.size() == 256) ? 2'b10 : ((q.size() > 0) ? 2'b01 : 2'b00);
        wt = (sent < 256) && (directed || $urandom_range(0, 3) != 0);
        dr = directed || ($urandom_range(0, 2) != 0);
        data = directed ? 8'(sent) : 8'($urandom());
        core_wt_sgn = wt; core_stream = data; dout_ready = dr;
        step();
        if (dr && q.size() > 0) void'(q.pop_front());
        if (wt) begin
          q.push_back(data);
          sent++;
          if (sent == 256) core_sign_reg = 8'h04;
        end
        core_wt_sgn = 1'b0;
        cyc++;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL block_timeout: got %0d sent/%0d queued want drained", sent, q.size());
    end
    step();
    checks++;
    if ({din_ready, busy, err, core_fifo_cnd} !== 5'b10000) begin
      errors++; $display("FAIL block_done: got %0b want 10000",
                         {din_ready, busy, err, core_fifo_cnd});
    end
  endtask

  task automatic test_rekey_ignored();
    key_in = 80'({$urandom(), $urandom(), $urandom()});
    key_valid = 1'b1;
    repeat (3) step();
    key_valid = 1'b0;
    checks++;
    if ({key_ready, core_strob_key, busy, din_ready} !== 4'b0001) begin
      errors++; $display("FAIL rekey_ignored: got %0b want 0001",
                         {key_ready, core_strob_key, busy, din_ready});
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] first;
    int sent;
    start_block(8'($urandom()));
    dout_ready = 1'b0;
    sent = 0;
    first = '0;
    for (int c = 0; c < 2000 && sent < 256; c++) begin
      core_wt_sgn = ($urandom_range(0, 4) != 0);
      core_stream = 8'($urandom());
      if (core_wt_sgn && sent == 0) first = core_stream;
      if (core_wt_sgn) sent++;
      step();
    end
    core_wt_sgn = 1'b0;
    core_sign_reg = 8'h04;
    step();
    checks++;
    if ({core_fifo_cnd, din_ready, dout_valid, err} !== 5'b10010 || dout !== first) begin
      errors++; $display("FAIL bp_full: got %0b/%0h want 10010/%0h",
                         {core_fifo_cnd, din_ready, dout_valid, err}, dout, first);
    end
    core_wt_sgn = 1'b1;
    step();
    core_wt_sgn = 1'b0;
    checks++;
    if ({err, dout_valid, din_ready, key_ready, core_strob_data, core_strob_key} !== 6'b100000) begin
      errors++; $display("FAIL bp_overflow: got %0b want 100000",
                         {err, dout_valid, din_ready, key_ready, core_strob_data, core_strob_key});
    end
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    checks++;
    if ({err, key_ready, core_strob_key} !== 3'b100) begin
      errors++; $display("FAIL err_sticky: got %0b want 100", {err, key_ready, core_strob_key});
    end
  endtask

  task automatic test_init_timeout();
    int first;
    test_key_load(80'({$urandom(), $urandom(), $urandom()}));
    core_sign_reg = 8'h02;
    first = -1;
    for (int k = 0; k < 2100 && first < 0; k++) begin
      if (err === 1'b1) first = k;
      else step();
    end
    checks++;
    if (first != 2048) begin
      errors++; $display("FAIL init_timeout: got %0d want 2048", first);
    end
    key_valid = 1'b1;
    repeat (3) step();
    key_valid = 1'b0;
    checks++;
    if ({err, key_ready, core_strob_key, din_ready} !== 4'b1000) begin
      errors++; $display("FAIL timeout_sticky: got %0b want 1000",
                         {err, key_ready, core_strob_key, din_ready});
    end
  endtask

  task automatic test_reset_mid_stream();
    logic [7:0] q[$];
    logic [7:0] data;
    logic [15:0] outs;
    test_key_load(80'({$urandom(), $urandom(), $urandom()}));
    test_init_complete(int'($urandom_range(0, 300)));
    start_block(8'($urandom()));
    dout_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (q.size() > 0) begin
        checks++;
        if (dout_valid !== 1'b1 || dout !== q[0]) begin
          errors++; $display("FAIL mid_dout%0d: got %0b/%0h want 1/%0h", i, dout_valid, dout, q[0]);
        end
      end
      data = 8'($urandom());
      core_wt_sgn = 1'b1; core_stream = data;
      step();
      if (q.size() > 0) void'(q.pop_front());
      q.push_back(data);
    end
    rst = 1'b0;
    core_wt_sgn = 1'b0;
    #1;
    outs = {key_ready, din_ready, dout_valid, busy, err, core_key, core_strob_key,
            core_strob_data, core_fifo_cnd, |dout, |core_data, 4'b0000};
    checks++;
    if (outs !== '0) begin
      errors++; $display("FAIL mid_reset_outputs: got %0h want 0", outs);
    end
    step();
    rst = 1'b1;
    dout_ready = 1'b0;
    core_sign_reg = 8'h00;
    step();
    checks++;
    if ({key_ready, dout_valid, core_fifo_cnd, busy} !== 5'b10000) begin
      errors++; $display("FAIL mid_reset_idle: got %0b want 10000",
                         {key_ready, dout_valid, core_fifo_cnd, busy});
    end
    test_key_load(80'({$urandom(), $urandom(), $urandom()}));
    test_init_complete(int'($urandom_range(0, 2000)));
    test_block(1'b0);
  endtask

  initial begin
    test_reset();
    test_key_load(80'h0123456789ABCDEF0F1E);
    test_init_complete(1153);
    test_block(1'b1);
    test_block(1'b0);
    test_rekey_ignored();
    test_backpressure();
    apply_reset();
    test_init_timeout();
    apply_reset();
    test_reset_mid_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "simulation time limit");
  end

endmodule
